// File: rtl/ifq_param.sv
// ifq_param -- parameterised instruction fetch queue.
//
// Fetches aligned WORDS-instruction lines from program memory into a
// DEPTH-line circular buffer and presents one instruction per cycle, with
// its PC, to dispatch. At most one memory request is outstanding. A request
// is issued only while a buffer slot is free, so a returning line always has
// room. A redirect flushes the buffer and aborts any outstanding request.
// Dispatch may then start in the middle of the first fetched line.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   m_rd_en            one-cycle request strobe
//   mem_addr           line-aligned fetch address
//   abort              kills the outstanding request (redirect while waiting)
//   d_valid, mem_data  response strobe and line (word i at [i*INSTR_W +: INSTR_W])
//   jump_branch_valid  redirect strobe; jump_branch_add is the target
//   d_rd_en            dispatch consumes the current instruction
//   empty, i_code      no instruction available / instruction at pc_out
//   pc_out, level      PC of i_code / number of lines held in the buffer
module ifq_param #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INSTR_W  = 32,
   parameter int unsigned       WORDS    = 4,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0000,
   localparam int unsigned      LINE_W   = WORDS * INSTR_W,
   localparam int unsigned      LVL_W    = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   output logic               m_rd_en,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               abort,
   input  logic               d_valid,
   input  logic [LINE_W-1:0]  mem_data,
   input  logic               jump_branch_valid,
   input  logic [ADDR_W-1:0]  jump_branch_add,
   input  logic               d_rd_en,
   output logic               empty,
   output logic [INSTR_W-1:0] i_code,
   output logic [ADDR_W-1:0]  pc_out,
   output logic [LVL_W-1:0]   level
);

   localparam int unsigned       OFF_W      = $clog2(WORDS * 4);  // byte-offset bits within a line
   localparam int unsigned       WSEL_W     = $clog2(WORDS);
   localparam int unsigned       PTR_W      = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(WORDS * 4);
   localparam logic [ADDR_W-1:0] LINE_MASK  = ~(LINE_BYTES - ADDR_W'(1));
   localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

   typedef enum logic {S_IDLE, S_WAIT} state_e;

   state_e                           state_q, state_d;
   logic [ADDR_W-1:0]                mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0]                pc_q, pc_d;
   logic [LVL_W-1:0]                 level_q, level_d;
   logic                             empty_q, empty_d;
   logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
   logic [WORDS-1:0][INSTR_W-1:0]    buf_q [DEPTH];

   logic              redirect, req, push, consume, pop;
   logic [WSEL_W-1:0] word_sel;

   // Word of the head line that pc_out points at.
   assign word_sel = pc_q[OFF_W-1:2];

   // Redirect overrides every other event in its cycle.
   assign redirect = jump_branch_valid;
   // IDLE means no request is outstanding, so level alone counts the used
   // credits; a request therefore always has a free slot to land in.
   assign req      = (state_q == S_IDLE) && (level_q < LVL_W'(DEPTH)) && !redirect;
   assign push     = (state_q == S_WAIT) && d_valid && !redirect;
   assign consume  = d_rd_en && !empty_q && !redirect;
   assign pop      = consume && (word_sel == WSEL_W'(WORDS - 1));

   // Fetch FSM next state.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      if (redirect) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (req)     state_d = S_WAIT;
            S_WAIT:  if (d_valid) state_d = S_IDLE;
            default:              state_d = S_IDLE;
         endcase
      end
   end

   // Datapath next state: addresses, PC, occupancy, pointers.
   always_comb begin
      mem_addr_d = mem_addr_q;
      pc_d       = pc_q;
      level_d    = level_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (redirect) begin
         mem_addr_d = jump_branch_add & LINE_MASK;
         pc_d       = jump_branch_add & WORD_MASK;
         level_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         if (push) begin
            mem_addr_d = mem_addr_q + LINE_BYTES;
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         end
         if (consume) pc_d = pc_q + ADDR_W'(4);
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
      empty_d = (level_d == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q    <= S_IDLE;
         mem_addr_q <= RESET_PC;
         pc_q       <= RESET_PC;
         level_q    <= '0;
         empty_q    <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         pc_q       <= pc_d;
         level_q    <= level_d;
         empty_q    <= empty_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // NOTE: the line storage is deliberately not reset; level/empty gate every read of it.
   always_ff @(posedge clk) begin
      if (push) buf_q[wr_ptr_q] <= mem_data;
   end

   assign m_rd_en  = req;
   assign mem_addr = mem_addr_q;
   assign abort    = redirect && (state_q == S_WAIT);
   assign empty    = empty_q;
   assign level    = level_q;
   assign pc_out   = pc_q;
   assign i_code   = buf_q[rd_ptr_q][word_sel];

endmodule

// File: doc/ifq_param.md
# ifq_param

Parametrised instruction fetch queue between program memory and dispatch. It fetches aligned multi-word lines into a DEPTH-line circular buffer and presents one instruction per cycle with its PC. Compared with the fixed 128-bit/4-deep queue, it adds:
- configurable line width and depth;
- a tracked single-outstanding memory request with real `abort` on redirect;
- unaligned redirect targets (dispatch starts mid-line);
- credit-based fill, so a returning line is never dropped for lack of space.

## Interface
Parameters:
- ADDR_W, 32, address/PC width
- INSTR_W, 32, instruction width; PC advances 4 per instruction
- WORDS, 4, instructions per memory line (power of 2, ≥2); LINE_W = WORDS*INSTR_W
- DEPTH, 4, buffer lines (power of 2, ≥2)
- RESET_PC, 32'h00400000, PC after reset (line-aligned)

Ports (clock is `clk`; reset is `rst`, asynchronous, active-low):
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- m_rd_en  out  1  request strobe; one-cycle pulse per request
- mem_addr  out  ADDR_W  line-aligned fetch address, stable from request until response or abort
- abort  out  1  kills the outstanding request
- d_valid  in  1  response strobe for the outstanding request
- mem_data  in  LINE_W  response line; word i at bits [i*INSTR_W +: INSTR_W]
- jump_branch_valid  in  1  redirect strobe
- jump_branch_add  in  ADDR_W  redirect target; bits [1:0] ignored
- d_rd_en  in  1  dispatch consumes current instruction
- empty  out  1  no instruction available
- i_code  out  INSTR_W  instruction at pc_out
- pc_out  out  ADDR_W  PC of i_code
- level  out  $clog2(DEPTH)+1  lines held in the buffer

## Operation
- Fetch FSM, two states:
  - IDLE → WAIT when a request is issued.
  - WAIT → IDLE on d_valid (line pushed) or on redirect (abort).
- Request condition: m_rd_en = IDLE & (level + 0) < DEPTH & ~jump_branch_valid. The WAIT request holds one credit, so a request is only issued when a free slot exists.
- mem_addr register is updated only at response or redirect:
  - On d_valid push: mem_addr += WORDS*4; wraps mod 2^ADDR_W.
  - On redirect: mem_addr ← jump_branch_add with the low $clog2(WORDS*4) bits zeroed.
- abort = jump_branch_valid & (state == WAIT), combinational. Memory returns no d_valid for an aborted request; d_valid in the abort cycle is discarded.
- Dispatch:
  - i_code = word pc_out[$clog2(WORDS*4)-1:2] of the head line.
  - On d_rd_en & ~empty: pc_out += 4.
  - The head line is popped when the consumed word is the last in the line (offset WORDS-1).
- Redirect priority: jump_branch_valid overrides d_valid, d_rd_en and request.
  - Buffer flushed; level ← 0.
  - pc_out ← target with bits [1:0] zeroed; FSM → IDLE.
  - Dispatch then starts at the target's word offset within the fetched line.
- Push and pop in the same cycle leave level unchanged; pointers wrap mod DEPTH.
- d_valid in IDLE (protocol violation) is ignored.

## Timing
- Reset values:
  - mem_addr = RESET_PC, pc_out = RESET_PC
  - empty = 1, level = 0, abort = 0, FSM = IDLE
  - m_rd_en = 1 in the first cycle after reset release
- Request in cycle t, d_valid in t+k (k ≥ 1): line is visible at cycle t+k+1 (empty = 0, level += 1). The earliest next request is also t+k+1.
- empty, level and pc_out are registered. i_code is combinational from the buffer head and pc_out.
- Redirect in cycle r:
  - abort in r (if WAIT).
  - In r+1: empty = 1, pc_out = target, m_rd_en = 1 with the aligned target.
- Reset asserted mid-request: all state returns to reset values immediately. Any response before the first post-reset request is ignored.
- Sustained throughput, given zero-stall memory latency k and continuous d_rd_en: one line per k+1 cycles.

## Test plan
- Reset, memory latency 2:
  - m_rd_en at cycle 0 with mem_addr = 0x00400000.
  - After 4 d_rd_en, pc_out = 0x00400010 and i_code = word 0 of the second line.
- Fill with d_rd_en = 0, DEPTH = 4: exactly 4 requests (0x00400000 … 0x00400030), then level = 4 and m_rd_en stays 0. One 4-word dispatch pops a line, and the next request is to 0x00400040.
- Redirect to 0x00401000 during WAIT with d_valid in the same cycle: abort = 1, data discarded, level = 0. Next cycle mem_addr = 0x00401000, m_rd_en = 1.
- Unaligned redirect to 0x0040100A: mem_addr = 0x00401000, pc_out = 0x00401008, and the first i_code is word 2. The head line pops after 2 reads, then pc_out = 0x00401010.
- At level = DEPTH-1 with one outstanding request: a simultaneous last-word pop and d_valid leave level = DEPTH-1, and no data is lost.
- rst low mid-WAIT: outputs return to reset values asynchronously, and a stale d_valid after release is ignored.
